// File: rtl/pcs_am_tx_if.sv
// Block-stream handshake bundle between scramblers, pcs_am_tx and the gearbox.
// The slave view is the inserter; the master view is the surrounding path.
interface pcs_am_tx_if #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66
);
    logic                        valid_i;
    logic [LANE_N*BLOCK_W-1:0]   data_i;
    logic                        ready_o;
    logic                        ready_i;
    logic                        valid_o;
    logic                        am_o;
    logic [LANE_N*BLOCK_W-1:0]   data_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, am_o, data_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, am_o, data_o
    );
endinterface

// File: rtl/pcs_am_tx.sv
// pcs_am_tx: multi-lane PCS TX alignment-marker inserter with running BIP3/BIP7.
// Optional macro PCS_AM_ERR_INJ_EN adds err_inj_i for per-lane BIP error injection.
module pcs_am_tx #(
    parameter int LANE_N    = 4,
    parameter int BLOCK_W   = 66,
    parameter int AM_PERIOD = 16383,
    parameter int AM_CNT_W  = $clog2(AM_PERIOD + 1),
    parameter logic [24*LANE_N-1:0] AM_M =
        {24'h3DA279, 24'h9B65C5, 24'hE6C4F0, 24'h4776C0}
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PCS_AM_ERR_INJ_EN
    input  logic [LANE_N-1:0] err_inj_i,
`endif
    pcs_am_tx_if.slave        bus
);
    typedef logic [LANE_N-1:0][BLOCK_W-1:0] lanes_t;
    typedef logic [LANE_N-1:0][7:0]         bips_t;

    // Byte-wise XOR of the payload; the sync bits land on BIP bits 3 and 4.
    function automatic logic [7:0] bip_fold(input logic [BLOCK_W-1:0] b);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r = r ^ b[8*j+2 +: 8];
        r[3] = r[3] ^ b[0];
        r[4] = r[4] ^ b[1];
        return r;
    endfunction

    lanes_t              din, am_blk, data_q, data_d;
    bips_t               bip_q, bip_d;
    logic                valid_q, valid_d;
    logic                am_q, am_d;
    logic                pend_q, pend_d;
    logic [AM_CNT_W-1:0] cnt_q, cnt_d;
    logic [LANE_N-1:0]   inj_q;
    logic                adv;

    assign din         = bus.data_i;
    assign adv         = bus.ready_i | ~valid_q;
    assign bus.ready_o = adv & ~pend_q & ~reset;
    assign bus.valid_o = valid_q;
    assign bus.am_o    = am_q;
    assign bus.data_o  = data_q;

`ifdef PCS_AM_ERR_INJ_EN
    logic [LANE_N-1:0] inj_d;

    // A pulse landing in the AM load cycle is kept for the following AM.
    always_comb begin
        inj_d = inj_q | err_inj_i;
        if (adv && pend_q) inj_d = err_inj_i;
    end

    always_ff @(posedge clk) begin
        if (reset) inj_q <= '0;
        else       inj_q <= inj_d;
    end
`else
    assign inj_q = '0;
`endif

    for (genvar i = 0; i < LANE_N; i++) begin : g_lane
        logic [7:0] m0, m1, m2, b3;
        assign m0 = AM_M[24*i      +: 8];
        assign m1 = AM_M[24*i + 8  +: 8];
        assign m2 = AM_M[24*i + 16 +: 8];
        assign b3 = bip_q[i] ^ {8{inj_q[i]}};
        assign am_blk[i] = {~b3, ~m2, ~m1, ~m0, b3, m2, m1, m0, 2'b01};
    end

    always_comb begin
        valid_d = valid_q;
        am_d    = am_q;
        data_d  = data_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        bip_d   = bip_q;
        if (adv) begin
            if (pend_q) begin
                // The accumulator restarts from the marker exactly as sent.
                valid_d = 1'b1;
                am_d    = 1'b1;
                data_d  = am_blk;
                pend_d  = 1'b0;
                cnt_d   = '0;
                for (int l = 0; l < LANE_N; l++) bip_d[l] = bip_fold(am_blk[l]);
            end else if (bus.valid_i) begin
                valid_d = 1'b1;
                am_d    = 1'b0;
                data_d  = din;
                cnt_d   = cnt_q + AM_CNT_W'(1);
                if (cnt_q == AM_CNT_W'(AM_PERIOD - 1)) pend_d = 1'b1;
                for (int l = 0; l < LANE_N; l++) bip_d[l] = bip_q[l] ^ bip_fold(din[l]);
            end else begin
                valid_d = 1'b0;
                am_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            am_q    <= 1'b0;
            data_q  <= '0;
            pend_q  <= 1'b1;
            cnt_q   <= '0;
            bip_q   <= '0;
        end else begin
            valid_q <= valid_d;
            am_q    <= am_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            bip_q   <= bip_d;
        end
    end
endmodule

// File: tb/tb_pcs_am_tx.sv
// Directed bench for pcs_am_tx: transaction scoreboard of the output stream
// (AM every AM_PERIOD accepted blocks, BIP from the bits sent) plus literal pins.
module tb_pcs_am_tx;
    localparam int LANE_N    = 4;
    localparam int BLOCK_W   = 66;
    localparam int AM_PERIOD = 4;
    localparam int W         = LANE_N * BLOCK_W;
    localparam logic [23:0] MK [LANE_N] = '{24'h4776C0, 24'hE6C4F0, 24'h9B65C5, 24'h3DA279};

    typedef logic [LANE_N-1:0][BLOCK_W-1:0] blk_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pcs_am_tx_if #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W)) bus ();
`ifdef PCS_AM_ERR_INJ_EN
    logic [LANE_N-1:0] err_inj = '0;
`endif

    pcs_am_tx #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .AM_PERIOD(AM_PERIOD)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef PCS_AM_ERR_INJ_EN
        .err_inj_i(err_inj),
`endif
        .bus      (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    task automatic fail_bound(input string name);
        n_chk++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    // BIP3 bit k straight from the bit-position definition.
    function automatic logic [7:0] m_bip(input logic [BLOCK_W-1:0] b);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++)
            for (int m = 0; m < 8; m++) r[k] = r[k] ^ b[k + 2 + 8*m];
        r[3] = r[3] ^ b[0];
        r[4] = r[4] ^ b[1];
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] m_am(input int lane, input logic [7:0] bip);
        logic [23:0] mk;
        logic [7:0]  m0, m1, m2;
        mk = MK[lane];
        m0 = mk[7:0];
        m1 = mk[15:8];
        m2 = mk[23:16];
        return {~bip, ~m2, ~m1, ~m0, bip, m2, m1, m0, 2'b01};
    endfunction

    function automatic logic [W-1:0] rnd_blk();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Scoreboard / model state
    blk_t                   sbq[$];
    blk_t                   am_log[$];
    int                     am_cyc[$];
    bit                     am_due = 1'b1;
    logic [LANE_N-1:0][7:0] m_acc = '0;
    int                     m_cnt = 0;
    int                     cyc = 0;
    int                     vlow = 0;
    bit                     p_ok = 1'b0;
    bit                     p_rst = 1'b0;
    logic                   p_vo, p_ri, p_ro, p_vi, p_am;
    blk_t                   p_do;

    always @(negedge clk) begin
        blk_t e;
        cyc++;
        if (reset) begin
            chk("rst_ready_o", bus.ready_o, 1'b0);
            if (p_rst) chk("rst_valid_o", bus.valid_o, 1'b0);
            sbq.delete();
            am_due = 1'b1;
            m_acc  = '0;
            m_cnt  = 0;
            p_ok   = 1'b0;
        end else begin
            if (p_ok) begin
                if (p_vo && !p_ri) begin
                    chk("stall_valid", bus.valid_o, 1'b1);
                    chk("stall_am", bus.am_o, p_am);
                    chk("stall_data", bus.data_o, p_do);
                end else if (!p_ro) begin
                    chk("am_load_valid", bus.valid_o, 1'b1);
                    chk("am_load_flag", bus.am_o, 1'b1);
                end else if (p_vi) begin
                    chk("data_load_valid", bus.valid_o, 1'b1);
                    chk("data_load_flag", bus.am_o, 1'b0);
                end else begin
                    chk("bubble_valid", bus.valid_o, 1'b0);
                end
            end
            if (bus.valid_o && !bus.ready_i) chk("ready_o_stall", bus.ready_o, 1'b0);
            if (!bus.valid_o) vlow++;
            if (bus.valid_o && bus.ready_i) begin
                if (am_due) begin
                    for (int l = 0; l < LANE_N; l++) e[l] = m_am(l, m_acc[l]);
                    chk("out_am_flag", bus.am_o, 1'b1);
                    chk("out_am_block", bus.data_o, e);
                    for (int l = 0; l < LANE_N; l++) m_acc[l] = m_bip(e[l]);
                    am_due = 1'b0;
                    m_cnt  = 0;
                    am_cyc.push_back(cyc);
                    am_log.push_back(bus.data_o);
                end else begin
                    chk("out_data_flag", bus.am_o, 1'b0);
                    if (sbq.size() == 0) begin
                        fail_bound("out_data_underflow");
                    end else begin
                        e = sbq.pop_front();
                        chk("out_data_block", bus.data_o, e);
                        for (int l = 0; l < LANE_N; l++) m_acc[l] = m_acc[l] ^ m_bip(e[l]);
                        m_cnt++;
                        if (m_cnt == AM_PERIOD) am_due = 1'b1;
                    end
                end
            end
            if (bus.valid_i && bus.ready_o) sbq.push_back(bus.data_i);
            p_ok = 1'b1;
        end
        p_rst = reset;
        p_vo  = bus.valid_o;
        p_ri  = bus.ready_i;
        p_ro  = bus.ready_o;
        p_vi  = bus.valid_i;
        p_am  = bus.am_o;
        p_do  = bus.data_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            bus.data_i = rnd_blk();
            tick(1);
        end
    endtask

    // Returns once an AM has just been loaded into the output register.
    task automatic wait_am(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick(1);
            if (bus.valid_o && bus.am_o) ok = 1'b1;
        end
    endtask

    initial begin
        bit          ok;
        int          n;
        int          v0;
        logic [65:0] e;

        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.data_i  = '0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;

        // Continuous all-ones traffic
        bus.valid_i = 1'b1;
        bus.data_i  = '1;
        tick(12);
        if (am_log.size() >= 2) begin
            e = {8'hFF, 8'hB8, 8'h89, 8'h3F, 8'h00, 8'h47, 8'h76, 8'hC0, 2'b01};
            chk("am0_lane0_literal", am_log[0][0], e);
            e = {8'hF7, 8'hB8, 8'h89, 8'h3F, 8'h08, 8'h47, 8'h76, 8'hC0, 2'b01};
            chk("am1_lane0_literal", am_log[1][0], e);
            e = {8'hF7, 8'h19, 8'h3B, 8'h0F, 8'h08, 8'hE6, 8'hC4, 8'hF0, 2'b01};
            chk("am1_lane1_literal", am_log[1][1], e);
            chk("am_spacing_cont", am_cyc[1] - am_cyc[0], 5);
        end else begin
            fail_bound("am_count_phase_a");
        end

        // Random traffic
        run(20);

        // Downstream stall of 3 cycles while an AM sits in the register
        wait_am(ok);
        if (!ok) fail_bound("wait_am_stall");
        else begin
            n = am_cyc.size();
            bus.ready_i = 1'b0;
            run(3);
            bus.ready_i = 1'b1;
            run(12);
            if (n >= 1 && am_cyc.size() > n + 1) begin
                chk("am_spacing_stall", am_cyc[n] - am_cyc[n-1], 8);
                chk("am_spacing_after_stall", am_cyc[n+1] - am_cyc[n], 5);
            end else fail_bound("am_count_stall");
        end

        // Upstream bubble of 2 cycles
        wait_am(ok);
        if (!ok) fail_bound("wait_am_bubble");
        else begin
            n  = am_cyc.size();
            v0 = vlow;
            bus.valid_i = 1'b0;
            run(2);
            bus.valid_i = 1'b1;
            run(12);
            chk("bubble_valid_low_cycles", vlow - v0, 2);
            if (am_cyc.size() > n + 1) chk("am_spacing_bubble", am_cyc[n+1] - am_cyc[n], 7);
            else fail_bound("am_count_bubble");
        end

        // Reset mid-stream: restart with AM carrying BIP 00
        run(2);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        n = am_log.size();
        run(8);
        if (am_log.size() > n) begin
            e = {8'hFF, 8'hB8, 8'h89, 8'h3F, 8'h00, 8'h47, 8'h76, 8'hC0, 2'b01};
            chk("am_after_reset_literal", am_log[n][0], e);
        end else fail_bound("am_after_reset");

        run(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
